// File: rtl/sprite_pkg.sv
// Shared sprite descriptor types and field widths used by the queue, the
// dispatcher and the sprite_render channels.
package sprite_pkg;

  localparam int SPRITE_ID_W    = 8;
  localparam int SPRITE_COORD_W = 16;
  localparam int SPRITE_SCALE_W = 8;

  typedef struct packed {
    logic [SPRITE_ID_W-1:0]    id;
    logic [SPRITE_COORD_W-1:0] x;
    logic [SPRITE_COORD_W-1:0] y;
    logic [SPRITE_SCALE_W-1:0] scale;
  } sprite_desc_t;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_idle_picker.sv
// Combinational round-robin search: first idle channel at or after rr_ptr_i,
// wrapping modulo N.
module rr_idle_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     idle_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic             valid_o,
  output logic [PTR_W-1:0] sel_o
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int SW = PTR_W + 1;

  logic [SW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    sel_o   = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, rr_ptr_i} + SW'(i);
      if (cand >= SW'(N)) cand = cand - SW'(N);
      if (!valid_o && idle_i[cand[PTR_W-1:0]]) begin
        valid_o = 1'b1;
        sel_o   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_dispatcher.sv
// Hands sprite descriptors from the draw queue to NUM_RENDERERS render
// channels, round-robin among idle channels, with a frame fence and counter.
module sprite_dispatcher
  import sprite_pkg::*;
#(
  parameter int NUM_RENDERERS = 4,
  parameter int ID_W          = SPRITE_ID_W,
  parameter int COORD_W       = SPRITE_COORD_W,
  parameter int SCALE_W       = SPRITE_SCALE_W,
  parameter int CNT_W         = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         sprite_queue_is_empty,
  input  logic [ID_W-1:0]              sprite_queue_sprite_id,
  input  logic [COORD_W-1:0]           sprite_queue_sprite_x,
  input  logic [COORD_W-1:0]           sprite_queue_sprite_y,
  input  logic [SCALE_W-1:0]           sprite_queue_sprite_scale,
  output logic                         sprite_queue_dequeue,
  output logic [NUM_RENDERERS-1:0]     rend_en,
  output logic [NUM_RENDERERS*ID_W-1:0]    rend_id,
  output logic [NUM_RENDERERS*COORD_W-1:0] rend_x,
  output logic [NUM_RENDERERS*COORD_W-1:0] rend_y,
  output logic [NUM_RENDERERS*SCALE_W-1:0] rend_scale,
  input  logic [NUM_RENDERERS-1:0]     rend_finished,
  output logic                         all_idle,
  output logic [CNT_W-1:0]             dispatched_count
);

  localparam int PTR_W = idx_w(NUM_RENDERERS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_RENDERERS-1:0] busy_q, busy_d;
  logic [PTR_W-1:0]         rr_q, rr_d;
  logic                     deq_q, deq_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     all_idle_q, all_idle_d;

  logic [ID_W-1:0]    id_q    [NUM_RENDERERS];
  logic [COORD_W-1:0] x_q     [NUM_RENDERERS];
  logic [COORD_W-1:0] y_q     [NUM_RENDERERS];
  logic [SCALE_W-1:0] scale_q [NUM_RENDERERS];

  logic [NUM_RENDERERS-1:0] idle_mask;
  logic                     pick_vld;
  logic [PTR_W-1:0]         pick_sel;
  logic [PTR_W-1:0]         rr_next;
  logic                     dispatch;

  // Channels freed this edge are still busy in busy_q, so they only become
  // eligible one edge later.
  assign idle_mask = ~busy_q;

  rr_idle_picker #(
    .N     (NUM_RENDERERS),
    .PTR_W (PTR_W)
  ) u_picker (
    .idle_i   (idle_mask),
    .rr_ptr_i (rr_q),
    .valid_o  (pick_vld),
    .sel_o    (pick_sel)
  );

  // The pending dequeue blocks dispatch so the queue head can advance first.
  assign dispatch = !sprite_queue_is_empty && !deq_q && !frame_start && pick_vld;
  assign rr_next  = (pick_sel == PTR_W'(NUM_RENDERERS - 1)) ? '0 : pick_sel + 1'b1;

  always_comb begin
    busy_d     = busy_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    deq_d      = dispatch;
    all_idle_d = sprite_queue_is_empty && (busy_q == '0) && !deq_q;
    if (frame_start) begin
      busy_d = '0;
      rr_d   = '0;
      cnt_d  = '0;
    end else begin
      busy_d = busy_q & ~rend_finished;
      if (dispatch) begin
        busy_d[pick_sel] = 1'b1;
        rr_d             = rr_next;
        cnt_d            = sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      rr_q       <= '0;
      deq_q      <= 1'b0;
      cnt_q      <= '0;
      all_idle_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      deq_q      <= deq_d;
      cnt_q      <= cnt_d;
      all_idle_q <= all_idle_d;
    end
  end

  // Descriptor fields persist after completion; rend_en alone marks validity.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_RENDERERS; k++) begin
        id_q[k]    <= '0;
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        scale_q[k] <= '0;
      end
    end else if (dispatch) begin
      id_q[pick_sel]    <= sprite_queue_sprite_id;
      x_q[pick_sel]     <= sprite_queue_sprite_x;
      y_q[pick_sel]     <= sprite_queue_sprite_y;
      scale_q[pick_sel] <= sprite_queue_sprite_scale;
    end
  end

  always_comb begin
    rend_id    = '0;
    rend_x     = '0;
    rend_y     = '0;
    rend_scale = '0;
    for (int k = 0; k < NUM_RENDERERS; k++) begin
      rend_id[k*ID_W +: ID_W]          = id_q[k];
      rend_x[k*COORD_W +: COORD_W]     = x_q[k];
      rend_y[k*COORD_W +: COORD_W]     = y_q[k];
      rend_scale[k*SCALE_W +: SCALE_W] = scale_q[k];
    end
  end

  assign rend_en              = busy_q;
  assign sprite_queue_dequeue = deq_q;
  assign dispatched_count     = cnt_q;
  assign all_idle             = all_idle_q;

endmodule
